instruction_encoder_queue: RTL
==============================

Name: instruction_encoder_queue

Overview:
- Opposite end of the control unit's 2-bit instruction decode path.
- Accepts one-hot instruction requests from the sequencer and encodes each into the 2-bit InstructionCode that the CU decoder consumes.
- Buffers encoded codes in a small FIFO and presents them over a valid/ready handshake.
- Rejects and flags illegal (non-one-hot) requests.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 2, code width; fixed at 2 for the current ISA, no other value supported.

Ports:
- Clock  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous active-low reset.
- InstructionIn  input  4  one-hot request: bit0=Add, bit1=Jump, bit2/bit3=ops 2/3.
- InValid  input  1  request valid.
- InReady  output  1  queue can accept (not full).
- InstructionCode  output  CW  head-of-queue code.
- OutValid  output  1  queue non-empty (head valid).
- OutReady  input  1  consumer takes head.
- IllegalPulse  output  1  one-cycle pulse: an illegal request was accepted.
- IllegalSticky  output  1  set on any illegal request; cleared only by reset.
- Count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (ResetN low, asynchronous): pointers=0, Count=0, OutValid=0, InstructionCode=0, InReady=1, IllegalPulse=0, IllegalSticky=0.
- Reset mid-operation discards all queued entries immediately.
- Encoding: 0001->00, 0010->01, 0100->10, 1000->11.
- Any other value (0000 or more than one bit set) is illegal.
- Push handshake: InValid & InReady in a cycle.
  - Legal: code written at write pointer and pointer advances.
  - Illegal: handshake completes (request consumed) but nothing is enqueued; IllegalPulse=1 next cycle; IllegalSticky set.
- Pop handshake: OutValid & OutReady; read pointer advances.
- InstructionCode is driven from the registered head entry. When OutValid=0 it holds the last value and must be ignored.
- InReady = (Count != DEPTH), from registered state only. When full, a same-cycle pop does not open the queue for a push.
- Simultaneous legal push and pop when 0<Count<DEPTH: Count unchanged, both pointers advance.
- Latency: legal push at cycle N -> OutValid=1 at N+1 when the queue was empty.
- Pointer wrap: log2(DEPTH) bits, natural wrap; full/empty derived from Count.
- No combinational path from InValid to OutValid, or from OutReady to InReady.

Optional Feature:
- Macro: INSTR_QUEUE_FALL_THROUGH_EN.
- Defined: when the queue is empty and a legal request arrives, OutValid and InstructionCode follow the input combinationally in the same cycle.
  - If OutReady=1 that cycle, the entry is consumed and never written; Count stays 0.
  - If OutReady=0, it is enqueued normally.
  - Illegal requests never fall through.
- Undefined: 1-cycle minimum latency as above; all outputs registered.

Decomposition:
- Shared package cu_pkg:
  - INSTR_CW=2.
  - Code constants OP_ADD=2'b00, OP_JUMP=2'b01, OP_2=2'b10, OP_3=2'b11.
  - One-hot constants.
  - Typedef instr_code_t. The decoder side reuses the same package.
- One natural sub-module: onehot_encoder4, combinational, outputs code plus legal flag.
- FIFO storage and control stay in the top.

Test Plan:
- Reset release, push 0001 then 0010 with OutReady=0 -> Count=2, OutValid=1 one cycle after first push, head 00. Set OutReady=1 -> codes 00 then 01, Count back to 0.
- Push 0110 -> no enqueue, Count=0, IllegalPulse=1 for exactly one cycle, IllegalSticky stays 1 until ResetN low. Same response for 0000.
- Push 4 legal codes with OutReady=0 -> InReady=0, Count=4. Push plus pop in the same cycle while full -> push not accepted, Count=3.
- Continuous push/pop at Count=2 for 10 cycles across pointer wrap -> output order equals input order, Count constant 2.
- ResetN low mid-stream with Count=3 -> immediately Count=0, OutValid=0, InReady=1.
- With INSTR_QUEUE_FALL_THROUGH_EN, empty queue, push 1000 with OutReady=1 -> same cycle OutValid=1, InstructionCode=11, Count remains 0. Without the macro -> OutValid=1 next cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared control-unit definitions: instruction code width, code constants and one-hot request patterns.
// Both the encoder queue and the CU decoder import this package.
package cu_pkg;

  localparam int INSTR_CW = 2;

  typedef logic [INSTR_CW-1:0] instr_code_t;

  localparam instr_code_t OP_ADD  = 2'b00;
  localparam instr_code_t OP_JUMP = 2'b01;
  localparam instr_code_t OP_2    = 2'b10;
  localparam instr_code_t OP_3    = 2'b11;

  localparam logic [3:0] OH_ADD  = 4'b0001;
  localparam logic [3:0] OH_JUMP = 4'b0010;
  localparam logic [3:0] OH_2    = 4'b0100;
  localparam logic [3:0] OH_3    = 4'b1000;

endpackage

// File: rtl/onehot_encoder4.sv
// Combinational 4-to-2 one-hot encoder. The legal flag is low for all-zero input and for
// any pattern with more than one bit set.
module onehot_encoder4
  import cu_pkg::*;
(
  input  logic [3:0]  onehot,
  output instr_code_t code,
  output logic        legal
);

  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves one unassigned (latch).
    code  = OP_ADD;
    legal = 1'b0;
    case (onehot)
      OH_ADD:  begin code = OP_ADD;  legal = 1'b1; end
      OH_JUMP: begin code = OP_JUMP; legal = 1'b1; end
      OH_2:    begin code = OP_2;    legal = 1'b1; end
      OH_3:    begin code = OP_3;    legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/instruction_encoder_queue.sv
// Encodes one-hot instruction requests into 2-bit codes and queues them behind a valid/ready handshake.
// Define INSTR_QUEUE_FALL_THROUGH_EN to let a legal request bypass an empty queue in the same cycle.
module instruction_encoder_queue
  import cu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = INSTR_CW
) (
  input  logic                       Clock,
  input  logic                       ResetN,
  input  logic [3:0]                 InstructionIn,
  input  logic                       InValid,
  output logic                       InReady,
  output logic [CW-1:0]              InstructionCode,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic                       IllegalPulse,
  output logic                       IllegalSticky,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  typedef logic [PW-1:0]   ptr_t;
  typedef logic [CNTW-1:0] cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  instr_code_t mem [DEPTH];
  ptr_t        wr_ptr, rd_ptr, rd_next;
  cnt_t        count_q, count_after_pop;
  instr_code_t head_q, head_d, enc_code;
  logic        enc_legal;
  logic        head_valid, push_hs, push_wr, pop, illegal_hs, ft_take;

  onehot_encoder4 u_enc (
    .onehot (InstructionIn),
    .code   (enc_code),
    .legal  (enc_legal)
  );

  // Ready depends only on registered occupancy, so a pop never opens a full queue in the same cycle.
  assign head_valid = (count_q != '0);
  assign InReady    = (count_q != FULL);
  assign push_hs    = InValid & InReady;
  assign illegal_hs = push_hs & ~enc_legal;

`ifdef INSTR_QUEUE_FALL_THROUGH_EN
  logic ft_active;
  assign ft_active       = ~head_valid & InValid & enc_legal;
  assign OutValid        = head_valid | ft_active;
  assign InstructionCode = ft_active ? enc_code : head_q;
  // A bypassed request taken by the consumer is never written into storage.
  assign ft_take         = ft_active & OutReady;
`else
  assign OutValid        = head_valid;
  assign InstructionCode = head_q;
  assign ft_take         = 1'b0;
`endif

  assign pop             = head_valid & OutReady;
  assign push_wr         = push_hs & enc_legal & ~ft_take;
  assign rd_next         = rd_ptr + ptr_t'(pop);
  assign count_after_pop = count_q - cnt_t'(pop);
  assign Count           = count_q;

  // Head register tracks the entry that will sit at the read pointer next cycle.
  always_comb begin
    head_d = head_q;
    if (push_wr && count_after_pop == '0)
      head_d = enc_code;
    else if (count_after_pop != '0)
      head_d = mem[rd_next];
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      head_q        <= OP_ADD;
      IllegalPulse  <= 1'b0;
      IllegalSticky <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      if (push_wr)
        wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)
        rd_ptr <= rd_next;
      count_q      <= count_after_pop + cnt_t'(push_wr);
      head_q       <= head_d;
      IllegalPulse <= illegal_hs;
      if (illegal_hs)
        IllegalSticky <= 1'b1;
    end
  end

  // NOTE: storage has no reset; count_q and head_q alone decide what is visible, so stale data is harmless.
  always_ff @(posedge Clock) begin
    if (push_wr)
      mem[wr_ptr] <= enc_code;
  end

endmodule
